instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage feeding the IF/ID pipeline register: drives hit, nextPC and instruction into it.
//  Holds the PC and a direct-mapped instruction cache with one word per line.
//  A refill FSM fetches missing words from instruction memory over a req/ready handshake.
//  Honours hazard stalls and branch redirects from later stages.
// PARAMETERS
//  LINES     16   cache lines (power of 2); IDXW = log2(LINES)
//  RESET_PC  0    PC value loaded on reset (word aligned)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  stall         in   1   hazard unit: hold PC (IF/ID keeps current contents)
//  branchTaken   in   1   redirect request from EX/MEM
//  branchTarget  in   32  redirect address (bits[1:0] ignored, treated as 0)
//  memReq        out  1   refill request to instruction memory
//  memAddr       out  32  refill word address, {PC[31:2],2'b00}
//  memReady      in   1   memory returns memData this cycle
//  memData       in   32  refill word
//  hit           out  1   instruction valid this cycle (cache hit)
//  nextPC        out  32  PC+4 of the presented instruction
//  instruction   out  32  fetched word; 32'b0 (NOP) when hit=0
// BEHAVIOUR
//  Lookup: index=PC[IDXW+1:2], tag=PC[31:IDXW+2]; hit = LOOKUP & valid[index] & tag match.
//  hit, instruction, nextPC are combinational from PC and the cache. nextPC=PC+4 always, mod 2^32.
//  Reset: PC<=RESET_PC, all valid bits<=0, state<=LOOKUP, redirect pending<=0.
//   Outputs during and after reset: hit=0, instruction=0, memReq=0, nextPC=RESET_PC+4.
//  FSM states: LOOKUP, REFILL.
//  LOOKUP, priority order:
//   1. branchTaken: PC<=branchTarget, regardless of stall or hit.
//   2. stall: PC held. Cache lookup still occurs, but a miss does not start a refill.
//   3. hit: PC<=PC+4.
//   4. miss: go to REFILL; PC held.
//  REFILL:
//   - memReq=1 and memAddr stable until memReady; hit=0; instruction=0.
//   - memReady: write memData and the tag into the line, set valid, return to LOOKUP.
//     The next cycle hits at the same PC, so refill penalty = memory latency + 1 cycle.
//   - branchTaken in REFILL: latch branchTarget into the redirect register, set pending.
//     The refill completes normally.
//     On return to LOOKUP: PC<=redirect and pending clears.
//     A later branchTaken overwrites the latched target (last one wins).
//   - stall is ignored in REFILL.
//  memReady outside REFILL is ignored; no cache write.
//  Reset mid-refill aborts it: memReq=0 on the following cycle, nothing written.
//  Line replacement: a miss overwrites the indexed line unconditionally.
//   Aliasing addresses thrash; each access refills.
//  PC wrap: 32'hFFFFFFFC + 4 -> 32'h00000000, no flag.
// TESTING
//  T1 reset, RESET_PC=0, memReady after 2 cycles with data 0x11 -> memReq=1, memAddr=0.
//     Then hit=1, instruction=0x11, nextPC=4 on the cycle after return.
//  T2 fill addresses 0,4,8, then branchTaken to 0 -> three consecutive hits.
//     Returned words are the refilled ones; nextPC is 4, 8, 12.
//  T3 hit at PC=4 with stall=1 for 3 cycles -> PC stays 4, hit=1, nextPC=8 throughout.
//  T4 miss at PC=0x20; branchTaken to 0x40 mid-refill; memReady.
//     -> line 0x20 valid; PC=0x40 next; memReq reasserts with memAddr=0x40.
//  T5 addresses 0x0 and 0x40 alias (LINES=16); alternating fetch.
//     -> every fetch misses and refills with the correct data.
//  T6 rst=1 during REFILL -> memReq=0 next cycle; PC=RESET_PC; a previously cached line now misses.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage feeding the IF/ID pipeline register. Holds the PC and a
//   direct-mapped instruction cache with one 32-bit word per line. On a miss a
//   two-state FSM (LOOKUP/REFILL) fetches the word from instruction memory
//   over a req/ready handshake. Stalls hold the PC; branch redirects from
//   later stages overwrite it, and are remembered if they arrive mid-refill.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous active-high reset
//   stall        in   1   hold PC (ignored during refill)
//   branchTaken  in   1   redirect request
//   branchTarget in  32   redirect address, bits [1:0] forced to 0
//   memReq       out  1   refill request
//   memAddr      out 32   refill word address
//   memReady     in   1   memData valid this cycle
//   memData      in  32   refill word
//   hit          out  1   instruction valid this cycle
//   nextPC       out 32   PC + 4 of the presented instruction
//   instruction  out 32   fetched word, zero (NOP) when hit = 0
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int          LINES    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic        hit,
  output logic [31:0] nextPC,
  output logic [31:0] instruction
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 30 - IDXW;

  localparam logic [0:0] S_LOOKUP = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  logic [31:0]      r_pc;
  logic [0:0]       r_state;
  logic [LINES-1:0] r_valid;
  logic [TAGW-1:0]  r_tag  [LINES];
  logic [31:0]      r_data [LINES];
  logic [31:0]      r_redirect;
  logic             r_redirect_pend;

  logic [IDXW-1:0]  w_idx;
  logic [TAGW-1:0]  w_tag;
  logic             w_hit;
  logic             w_fill;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_target;

  // Cache lookup, refill-write enable and next-address arithmetic.
  always_comb begin
    w_idx      = r_pc[IDXW+1:2];
    w_tag      = r_pc[31:IDXW+2];
    w_hit      = (r_state == S_LOOKUP) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // A reset in the same cycle as memReady aborts the refill without writing.
    w_fill     = (r_state == S_REFILL) && memReady && !rst;
    w_pc_plus4 = r_pc + 32'd4;
    // Masking (rather than slicing) keeps every target bit in use.
    w_target   = branchTarget & 32'hFFFF_FFFC;
  end

  // Output decode: combinational from PC, FSM state and cache contents.
  always_comb begin
    hit     = w_hit;
    nextPC  = w_pc_plus4;
    memReq  = (r_state == S_REFILL);
    memAddr = r_pc & 32'hFFFF_FFFC;
    if (w_hit) begin
      instruction = r_data[w_idx];
    end else begin
      instruction = 32'h0000_0000;
    end
  end

  // Cache data/tag storage; contents are qualified by r_valid so need no reset.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= memData;
      r_tag[w_idx]  <= w_tag;
    end
  end

  // PC, valid bits, refill FSM and pending-redirect register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc            <= RESET_PC;
      r_state         <= S_LOOKUP;
      r_valid         <= '0;
      r_redirect      <= 32'h0000_0000;
      r_redirect_pend <= 1'b0;
    end else begin
      case (r_state)
        S_LOOKUP: begin
          if (branchTaken) begin
            r_pc <= w_target;
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (w_hit) begin
            r_pc <= w_pc_plus4;
          end else begin
            r_state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (memReady) begin
            r_valid[w_idx]  <= 1'b1;
            r_state         <= S_LOOKUP;
            r_redirect_pend <= 1'b0;
            // A branch arriving with memReady is the newest target and wins.
            if (branchTaken) begin
              r_pc <= w_target;
            end else if (r_redirect_pend) begin
              r_pc <= r_redirect;
            end else begin
              r_pc <= r_pc;
            end
          end else if (branchTaken) begin
            r_redirect      <= w_target;
            r_redirect_pend <= 1'b1;
          end
        end
        default: begin
          r_state <= S_LOOKUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memReady;
  logic [31:0] memData;
  logic        hit;
  logic [31:0] nextPC;
  logic [31:0] instruction;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];

  instruction_fetch_unit #(.LINES(16), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .memReq       (memReq),
    .memAddr      (memAddr),
    .memReady     (memReady),
    .memData      (memData),
    .hit          (hit),
    .nextPC       (nextPC),
    .instruction  (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data);
    sb_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  // Compare the current (negedge) outputs against the oldest expected fetch.
  task automatic expect_hit(input string tag);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hit"}, {31'b0, hit}, 32'd1);
      chk({tag, "_instr"}, instruction, e.data);
      chk({tag, "_nextpc"}, nextPC, e.addr + 32'd4);
    end
  endtask

  // Wait (bounded) for a refill request, check it, hold it lat cycles, answer.
  task automatic refill(input logic [31:0] addr, input logic [31:0] data, input int lat);
    int n;
    n = 0;
    while (memReq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("refill_req", {31'b0, memReq}, 32'd1);
    chk("refill_addr", memAddr, addr);
    push(addr, data);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk("refill_hold_req", {31'b0, memReq}, 32'd1);
      chk("refill_hold_addr", memAddr, addr);
      chk("refill_nohit", {31'b0, hit}, 32'd0);
      chk("refill_nop", instruction, 32'd0);
    end
    memData  = data;
    memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    memData  = 32'd0;
  endtask

  // From a hit cycle: redirect to an aliasing address, expect a miss and refill.
  task automatic alias_fetch(input logic [31:0] addr, input logic [31:0] data);
    branchTaken  = 1'b1;
    branchTarget = addr;
    @(negedge clk);
    branchTaken = 1'b0;
    chk("t5_alias_miss", {31'b0, hit}, 32'd0);
    refill(addr, data, 2);
    expect_hit("t5_alias_hit");
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 32'd0;
    memReady     = 1'b0;
    memData      = 32'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_hit", {31'b0, hit}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_memreq", {31'b0, memReq}, 32'd0);
    chk("rst_nextpc", nextPC, 32'd4);
    rst = 1'b0;

    // T1: first miss at 0, two-cycle memory latency
    refill(32'h0, 32'h11, 2);
    expect_hit("t1_hit0");

    // T2: fill 4 and 8, then branch back to 0 for three consecutive hits
    refill(32'h4, 32'hD004, 1);
    expect_hit("t2_fill4");
    refill(32'h8, 32'hD008, 2);
    expect_hit("t2_fill8");
    branchTaken  = 1'b1;
    branchTarget = 32'h0;
    push(32'h0, 32'h11);
    push(32'h4, 32'hD004);
    push(32'h8, 32'hD008);
    @(negedge clk);
    branchTaken = 1'b0;
    expect_hit("t2_rehit0");
    @(negedge clk);
    expect_hit("t2_rehit4");
    @(negedge clk);
    expect_hit("t2_rehit8");
    branchTaken  = 1'b1;
    branchTarget = 32'h6;  // low bits must be ignored -> 4

    // T3: stall while hitting at PC=4
    @(negedge clk);
    branchTaken = 1'b0;
    push(32'h4, 32'hD004);
    expect_hit("t3_at4");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push(32'h4, 32'hD004);
      expect_hit("t3_stalled");
    end

    // T4: branch arriving mid-refill is applied after the refill completes
    stall        = 1'b0;
    branchTaken  = 1'b1;
    branchTarget = 32'h20;
    @(negedge clk);
    branchTaken = 1'b0;
    chk("t4_miss20", {31'b0, hit}, 32'd0);
    chk("t4_pc20", nextPC, 32'h24);
    @(negedge clk);
    chk("t4_req20", {31'b0, memReq}, 32'd1);
    chk("t4_addr20", memAddr, 32'h20);
    branchTaken  = 1'b1;
    branchTarget = 32'h40;
    @(negedge clk);
    branchTaken = 1'b0;
    chk("t4_req_stable", {31'b0, memReq}, 32'd1);
    chk("t4_addr_stable", memAddr, 32'h20);
    memReady = 1'b1;
    memData  = 32'hD020;
    @(negedge clk);
    memReady = 1'b0;
    memData  = 32'd0;
    chk("t4_redirected_pc", nextPC, 32'h44);
    chk("t4_miss40", {31'b0, hit}, 32'd0);
    refill(32'h40, 32'hD040, 3);
    expect_hit("t4_hit40");
    branchTaken  = 1'b1;
    branchTarget = 32'h20;
    @(negedge clk);
    branchTaken = 1'b0;
    push(32'h20, 32'hD020);
    expect_hit("t4_line20_valid");

    // T5: 0x0 and 0x40 share line 0 and thrash
    alias_fetch(32'h0, 32'hA000);
    alias_fetch(32'h40, 32'hA040);
    alias_fetch(32'h0, 32'hA001);
    alias_fetch(32'h40, 32'hA041);

    // T6: reset during a refill aborts it and invalidates the cache
    branchTaken  = 1'b1;
    branchTarget = 32'h10;
    @(negedge clk);
    branchTaken = 1'b0;
    @(negedge clk);
    chk("t6_req10", {31'b0, memReq}, 32'd1);
    chk("t6_addr10", memAddr, 32'h10);
    rst      = 1'b1;
    memReady = 1'b1;
    memData  = 32'hBAD0_BAD0;
    @(negedge clk);
    memReady = 1'b0;
    memData  = 32'd0;
    chk("t6_req_dropped", {31'b0, memReq}, 32'd0);
    chk("t6_nohit", {31'b0, hit}, 32'd0);
    chk("t6_pc_reset", nextPC, 32'd4);
    rst          = 1'b0;
    branchTaken  = 1'b1;
    branchTarget = 32'h20;
    @(negedge clk);
    branchTaken = 1'b0;
    chk("t6_line20_invalid", {31'b0, hit}, 32'd0);
    chk("t6_pc20", nextPC, 32'h24);
    refill(32'h20, 32'hC020, 1);
    expect_hit("t6_refill20");
    branchTaken  = 1'b1;
    branchTarget = 32'h10;
    @(negedge clk);
    branchTaken = 1'b0;
    chk("t6_aborted_not_written", {31'b0, hit}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
